// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
// Holds the state encoding, the size constants and the index-to-one-hot helper.
package rr_arbiter4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin pick: the search starts just after 'last' and wraps.
// 'last' itself is searched last, so it only wins when it is the sole requester.
module rr_pick
  import rr_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] w_base;
  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  logic [1:0] w_off;

  // Rotate so that requester (last+1) lands at bit 0.
  assign w_base = last + 2'd1;
  assign w_dbl  = {req, req} >> w_base;
  assign w_rot  = w_dbl[3:0];

  // Fixed-priority encode of the rotated vector; the lowest set bit wins.
  always_comb begin
    w_off = 2'd0;
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
  end

  // Undo the rotation to get the absolute requester index.
  assign idx = w_base + w_off;
  assign any = |req;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a registered one-hot grant and bounded hold time.
// A holder is forced to hand over after MAX_HOLD cycles, but only when someone else is waiting.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       v
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  state_e           r_state;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_gnt_id;
  logic             r_v;

  logic [1:0] w_pick_idx;
  logic       w_pick_any;
  logic       w_own_req;
  logic       w_others;

  rr_pick u_pick (
    .req  (req),
    .last (r_last),
    .idx  (w_pick_idx),
    .any  (w_pick_any)
  );

  assign w_own_req = req[r_last];
  assign w_others  = |(req & ~idx2onehot(r_last));

  // Arbitration state, hold counter and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= 2'd3;
      r_cnt    <= '0;
      r_gnt    <= 4'b0000;
      r_gnt_id <= 2'd0;
      r_v      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_state  <= ST_GRANT;
            r_gnt    <= idx2onehot(w_pick_idx);
            r_gnt_id <= w_pick_idx;
            r_last   <= w_pick_idx;
            r_cnt    <= CNT_W'(1);
            r_v      <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // Release beats preemption; the pick never returns the owner while others wait.
          if (!w_own_req && w_others) begin
            r_gnt    <= idx2onehot(w_pick_idx);
            r_gnt_id <= w_pick_idx;
            r_last   <= w_pick_idx;
            r_cnt    <= CNT_W'(1);
          end else if (!w_own_req) begin
            r_state  <= ST_IDLE;
            r_gnt    <= 4'b0000;
            r_gnt_id <= 2'd0;
            r_cnt    <= '0;
            r_v      <= 1'b0;
          end else if (r_cnt == HOLD_MAX && w_others) begin
            r_gnt    <= idx2onehot(w_pick_idx);
            r_gnt_id <= w_pick_idx;
            r_last   <= w_pick_idx;
            r_cnt    <= CNT_W'(1);
          end else if (r_cnt < HOLD_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= r_cnt;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_gnt    <= 4'b0000;
          r_gnt_id <= 2'd0;
          r_cnt    <= '0;
          r_v      <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign v      = r_v;

endmodule
